// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage data-memory access unit.
// Used by mem_access_unit and, with MEM_SUBWORD_EN, load_extend.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Load lane select and sign/zero extension; only built with MEM_SUBWORD_EN.
// off_i is the already-aligned lane offset captured at launch.
`ifdef MEM_SUBWORD_EN
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        unique case (off_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        unique case (funct3_i)
            F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  data_o = {24'd0, byte_sel};
            F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  data_o = {16'd0, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule
`endif

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: req/ack launch, pipeline stall, load result.
// Define MEM_SUBWORD_EN for byte/halfword loads and stores (funct3 honoured).
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  MemRead_i,
    input  logic                  MemWrite_i,
    input  logic [2:0]            funct3_i,
    input  logic [ADDR_WIDTH-1:0] ALUresult_i,
    input  logic [DATA_WIDTH-1:0] MemWdata_i,
    output logic                  MemStall_o,
    output logic [DATA_WIDTH-1:0] Readdata_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [3:0]            mem_be_o,
    input  logic                  mem_ack_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic [CNT_WIDTH-1:0]  stall_cnt_o
);

    state_e                state_q, state_d;
    logic                  access, launch, ack;
    logic [ADDR_WIDTH-1:0] addr_d, addr_q;
    logic [DATA_WIDTH-1:0] wdata_d, wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q, load_val;
    logic [3:0]            be_d, be_q;
    logic                  we_q;
    logic [CNT_WIDTH-1:0]  cnt_q;

    assign access = MemRead_i | MemWrite_i;
    assign addr_d = {ALUresult_i[ADDR_WIDTH-1:2], 2'b00};

`ifdef MEM_SUBWORD_EN
    logic [1:0] off_d, off_q;
    logic [2:0] funct3_q;

    // Misaligned halfword/word accesses collapse onto their aligned lane.
    always_comb begin
        off_d   = 2'b00;
        be_d    = BE_WORD;
        wdata_d = MemWdata_i;
        if (MemWrite_i) begin
            unique case (funct3_i)
                F3_SB: begin
                    off_d   = ALUresult_i[1:0];
                    be_d    = BE_BYTE << off_d;
                    wdata_d = {4{MemWdata_i[7:0]}};
                end
                F3_SH: begin
                    off_d   = {ALUresult_i[1], 1'b0};
                    be_d    = BE_HALF << off_d;
                    wdata_d = {2{MemWdata_i[15:0]}};
                end
                default: ;
            endcase
        end else begin
            unique case (funct3_i)
                F3_LB, F3_LBU: off_d = ALUresult_i[1:0];
                F3_LH, F3_LHU: off_d = {ALUresult_i[1], 1'b0};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            off_q    <= 2'b00;
            funct3_q <= 3'b000;
        end else if (launch) begin
            off_q    <= off_d;
            funct3_q <= funct3_i;
        end
    end

    load_extend u_load_extend (
        .rdata_i  (mem_rdata_i),
        .off_i    (off_q),
        .funct3_i (funct3_q),
        .data_o   (load_val)
    );
`else
    logic unused_sub;
    assign unused_sub = ^{funct3_i, ALUresult_i[1:0]};
    assign be_d       = BE_WORD;
    assign wdata_d    = MemWdata_i;
    assign load_val   = mem_rdata_i;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // DONE always returns to IDLE so the still-visible instruction is not relaunched.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (access) state_d = WAIT;
            WAIT:    if (mem_ack_i) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        MemStall_o = 1'b0;
        mem_req_o  = 1'b0;
        launch     = 1'b0;
        ack        = 1'b0;
        unique case (state_q)
            IDLE: begin
                MemStall_o = access;
                launch     = access;
            end
            WAIT: begin
                MemStall_o = 1'b1;
                mem_req_o  = 1'b1;
                ack        = mem_ack_i;
            end
            default: ;
        endcase
        MemStall_o = MemStall_o & rst_n_i;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= BE_NONE;
            we_q    <= 1'b0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            if (launch) begin
                addr_q  <= addr_d;
                wdata_q <= wdata_d;
                be_q    <= be_d;
                we_q    <= MemWrite_i;
            end
            if (ack && !we_q) rdata_q <= load_val;
            if (MemStall_o && !(&cnt_q)) cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_be_o    = be_q;
    assign Readdata_o  = rdata_q;
    assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a behavioural memory/pipeline model.
// Build with +define+MEM_SUBWORD_EN to exercise byte/halfword accesses.
module tb_mem_access_unit;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        MemRead_i, MemWrite_i;
    logic [2:0]  funct3_i;
    logic [31:0] ALUresult_i, MemWdata_i;
    logic        MemStall_o;
    logic [31:0] Readdata_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic [31:0] stall_cnt_o;

    int          pass_cnt = 0;
    int          total_cnt = 0;
    logic [31:0] exp_rd;
    longint      exp_cnt;

    always #5 clk_i = ~clk_i;

    mem_access_unit dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .MemRead_i   (MemRead_i),
        .MemWrite_i  (MemWrite_i),
        .funct3_i    (funct3_i),
        .ALUresult_i (ALUresult_i),
        .MemWdata_i  (MemWdata_i),
        .MemStall_o  (MemStall_o),
        .Readdata_o  (Readdata_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_be_o    (mem_be_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .stall_cnt_o (stall_cnt_o)
    );

    function automatic logic [31:0] ref_load(logic [2:0] f3, logic [31:0] a, logic [31:0] d);
        logic [31:0] v;
        v = d;
`ifdef MEM_SUBWORD_EN
        if (f3 == 3'd0 || f3 == 3'd4) begin
            v = (d >> (8 * a[1:0])) & 32'hFF;
            if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
        end else if (f3 == 3'd1 || f3 == 3'd5) begin
            v = (d >> (16 * a[1])) & 32'hFFFF;
            if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
        end
`endif
        return v;
    endfunction

    function automatic logic [3:0] ref_be(logic wr, logic [2:0] f3, logic [31:0] a);
        logic [3:0] b;
        b = 4'hF;
`ifdef MEM_SUBWORD_EN
        if (wr && f3 == 3'd0) b = 4'(1 << a[1:0]);
        if (wr && f3 == 3'd1) b = 4'(3 << (2 * a[1]));
`endif
        return b;
    endfunction

    function automatic logic [31:0] ref_wdata(logic wr, logic [2:0] f3, logic [31:0] wd);
        logic [31:0] w;
        w = wd;
`ifdef MEM_SUBWORD_EN
        if (wr && f3 == 3'd0) w = {24'd0, wd[7:0]} * 32'h01010101;
        if (wr && f3 == 3'd1) w = {16'd0, wd[15:0]} * 32'h00010001;
`endif
        return w;
    endfunction

    // Presents one instruction in MEM, plays the memory side, and reports what it saw.
    task automatic drive_access(
        input  logic        rd, wr,
        input  logic [2:0]  f3,
        input  logic [31:0] a, wd, rdat,
        input  int          n,
        output int          stalls, rises,
        output logic        o_we,
        output logic [31:0] o_addr, o_wdata,
        output logic [3:0]  o_be,
        output logic [31:0] o_rd, o_cnt,
        output bit          unstable, timed_out
    );
        int reqc;
        bit prev, fin;
        stalls = 0; rises = 0; reqc = 0; prev = 0; fin = 0;
        unstable = 0; timed_out = 0;
        o_we = 0; o_addr = 0; o_wdata = 0; o_be = 0; o_rd = 0; o_cnt = 0;
        MemRead_i = rd; MemWrite_i = wr; funct3_i = f3;
        ALUresult_i = a; MemWdata_i = wd; mem_rdata_i = rdat;
        for (int c = 0; c < 200 && !fin; c++) begin
            @(negedge clk_i);
            if (MemStall_o) stalls++;
            if (mem_req_o && !prev) begin
                rises++;
                o_we = mem_we_o; o_addr = mem_addr_o;
                o_wdata = mem_wdata_o; o_be = mem_be_o;
            end else if (mem_req_o) begin
                if (mem_we_o !== o_we || mem_addr_o !== o_addr ||
                    mem_wdata_o !== o_wdata || mem_be_o !== o_be) unstable = 1;
            end
            prev = mem_req_o;
            if (mem_req_o) begin
                reqc++;
                if (reqc == n) mem_ack_i = 1'b1;
            end
            if (!MemStall_o) begin
                fin = 1;
                o_rd = Readdata_o;
                o_cnt = stall_cnt_o;
            end
            @(posedge clk_i); #1;
            mem_ack_i = 1'b0;
        end
        timed_out = !fin;
        MemRead_i = 1'b0; MemWrite_i = 1'b0;
    endtask

    task automatic test_reset;
        rst_n_i = 1'b0; MemRead_i = 0; MemWrite_i = 0; funct3_i = 0;
        ALUresult_i = 0; MemWdata_i = 0; mem_ack_i = 0; mem_rdata_i = 0;
        #12;
        total_cnt++;
        if ({MemStall_o, mem_req_o, mem_we_o, mem_be_o} !== 7'd0 ||
            Readdata_o !== 0 || mem_addr_o !== 0 || mem_wdata_o !== 0 || stall_cnt_o !== 0)
            $display("FAIL reset_outputs got stall=%b req=%b we=%b be=%h rd=%h addr=%h wd=%h cnt=%0d want all zero",
                     MemStall_o, mem_req_o, mem_we_o, mem_be_o, Readdata_o, mem_addr_o, mem_wdata_o, stall_cnt_o);
        else pass_cnt++;
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
        exp_rd = 0; exp_cnt = 0;
    endtask

    task automatic test_idle;
        bit bad_stall, bad_req;
        bad_stall = 0; bad_req = 0;
        for (int i = 0; i < 10; i++) begin
            ALUresult_i = $urandom; MemWdata_i = $urandom; mem_rdata_i = $urandom;
            mem_ack_i = (i % 3 == 0);
            @(negedge clk_i);
            if (MemStall_o) bad_stall = 1;
            if (mem_req_o) bad_req = 1;
            @(posedge clk_i); #1;
        end
        mem_ack_i = 0;
        total_cnt++;
        if (bad_stall) $display("FAIL idle_stall got 1 want 0"); else pass_cnt++;
        total_cnt++;
        if (bad_req) $display("FAIL idle_req got 1 want 0"); else pass_cnt++;
        total_cnt++;
        if (stall_cnt_o !== 0) $display("FAIL idle_cnt got %0d want 0", stall_cnt_o); else pass_cnt++;
        total_cnt++;
        if (Readdata_o !== exp_rd) $display("FAIL idle_rdata got %h want %h", Readdata_o, exp_rd);
        else pass_cnt++;
    endtask

    task automatic test_lw;
        int st, rs; logic we; logic [31:0] ad, wd, rd, cn; logic [3:0] be; bit us, to;
        drive_access(1, 0, 3'd2, 32'h100, $urandom, 32'hDEADBEEF, 1,
                     st, rs, we, ad, wd, be, rd, cn, us, to);
        exp_rd = 32'hDEADBEEF; exp_cnt += 2;
        total_cnt++;
        if (to || st != 2) $display("FAIL lw_stalls got %0d (timeout=%0b) want 2", st, to); else pass_cnt++;
        total_cnt++;
        if (rd !== exp_rd) $display("FAIL lw_rdata got %h want %h", rd, exp_rd); else pass_cnt++;
        total_cnt++;
        if (cn !== 32'(exp_cnt)) $display("FAIL lw_cnt got %0d want %0d", cn, exp_cnt); else pass_cnt++;
        total_cnt++;
        if (rs != 1 || we !== 0 || ad !== 32'h100 || be !== 4'hF)
            $display("FAIL lw_req got reqs=%0d we=%b addr=%h be=%h want 1 0 00000100 f", rs, we, ad, be);
        else pass_cnt++;
        @(negedge clk_i);
        total_cnt++;
        if (mem_req_o !== 0 || MemStall_o !== 0)
            $display("FAIL lw_no_relaunch got req=%b stall=%b want 0 0", mem_req_o, MemStall_o);
        else pass_cnt++;
        @(posedge clk_i); #1;
    endtask

    task automatic test_sw;
        int st, rs; logic we; logic [31:0] ad, wd, rd, cn; logic [3:0] be; bit us, to;
        drive_access(0, 1, 3'd2, 32'h204, 32'h12345678, $urandom, 5,
                     st, rs, we, ad, wd, be, rd, cn, us, to);
        exp_cnt += 6;
        total_cnt++;
        if (to || st != 6) $display("FAIL sw_stalls got %0d (timeout=%0b) want 6", st, to); else pass_cnt++;
        total_cnt++;
        if (rs != 1 || we !== 1 || ad !== 32'h204 || be !== 4'hF || wd !== 32'h12345678)
            $display("FAIL sw_req got reqs=%0d we=%b addr=%h be=%h wd=%h want 1 1 00000204 f 12345678",
                     rs, we, ad, be, wd);
        else pass_cnt++;
        total_cnt++;
        if (us) $display("FAIL sw_stable got unstable want stable"); else pass_cnt++;
        total_cnt++;
        if (rd !== exp_rd) $display("FAIL sw_rdata got %h want %h", rd, exp_rd); else pass_cnt++;
        total_cnt++;
        if (cn !== 32'(exp_cnt)) $display("FAIL sw_cnt got %0d want %0d", cn, exp_cnt); else pass_cnt++;
    endtask

    task automatic test_subword;
        int st, rs; logic we; logic [31:0] ad, wd, rd, cn; logic [3:0] be; bit us, to;
        logic [31:0] want;
        drive_access(1, 0, 3'd0, 32'h103, 0, 32'h80FF_0000, 2,
                     st, rs, we, ad, wd, be, rd, cn, us, to);
        exp_rd = ref_load(3'd0, 32'h103, 32'h80FF_0000); exp_cnt += 3;
`ifdef MEM_SUBWORD_EN
        want = 32'hFFFFFF80;
`else
        want = 32'h80FF0000;
`endif
        total_cnt++;
        if (to || rd !== want || rd !== exp_rd) $display("FAIL lb_rdata got %h want %h", rd, want);
        else pass_cnt++;
        drive_access(1, 0, 3'd4, 32'h103, 0, 32'h80FF_0000, 1,
                     st, rs, we, ad, wd, be, rd, cn, us, to);
        exp_rd = ref_load(3'd4, 32'h103, 32'h80FF_0000); exp_cnt += 2;
        total_cnt++;
        if (to || rd !== exp_rd) $display("FAIL lbu_rdata got %h want %h", rd, exp_rd); else pass_cnt++;
        drive_access(0, 1, 3'd0, 32'h102, 32'h0000_00AB, 0, 1,
                     st, rs, we, ad, wd, be, rd, cn, us, to);
        exp_cnt += 2;
        total_cnt++;
        if (to || be !== ref_be(1, 3'd0, 32'h102) || wd !== ref_wdata(1, 3'd0, 32'hAB) || ad !== 32'h100)
            $display("FAIL sb_lanes got be=%h wd=%h addr=%h want %h %h 00000100",
                     be, wd, ad, ref_be(1, 3'd0, 32'h102), ref_wdata(1, 3'd0, 32'hAB));
        else pass_cnt++;
        total_cnt++;
        if (cn !== 32'(exp_cnt)) $display("FAIL sub_cnt got %0d want %0d", cn, exp_cnt); else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        bit seen;
        seen = 0;
        MemRead_i = 1; funct3_i = 3'd2; ALUresult_i = 32'h300; mem_rdata_i = 32'h55AA55AA;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk_i);
            seen = mem_req_o;
        end
        total_cnt++;
        if (!seen) $display("FAIL rstmid_req_rise got 0 want 1"); else pass_cnt++;
        #2 rst_n_i = 1'b0;
        #1;
        total_cnt++;
        if (mem_req_o !== 0 || MemStall_o !== 0 || stall_cnt_o !== 0)
            $display("FAIL rstmid_async got req=%b stall=%b cnt=%0d want 0 0 0", mem_req_o, MemStall_o, stall_cnt_o);
        else pass_cnt++;
        mem_ack_i = 1;
        @(posedge clk_i); #1;
        mem_ack_i = 0; MemRead_i = 0;
        rst_n_i = 1'b1;
        exp_rd = 0; exp_cnt = 0;
        @(negedge clk_i);
        mem_ack_i = 1;
        @(posedge clk_i); #1;
        mem_ack_i = 0;
        @(negedge clk_i);
        total_cnt++;
        if (mem_req_o !== 0 || MemStall_o !== 0 || Readdata_o !== exp_rd || stall_cnt_o !== 0)
            $display("FAIL rstmid_late_ack got req=%b stall=%b rd=%h cnt=%0d want 0 0 %h 0",
                     mem_req_o, MemStall_o, Readdata_o, stall_cnt_o, exp_rd);
        else pass_cnt++;
        @(posedge clk_i); #1;
    endtask

    task automatic test_back_to_back;
        int st1, st2, rs1, rs2; logic we; logic [31:0] ad, wd, rd, cn; logic [3:0] be; bit us, to1, to2;
        drive_access(1, 0, 3'd2, 32'h40, 0, 32'hA5A5_0001, 1,
                     st1, rs1, we, ad, wd, be, rd, cn, us, to1);
        drive_access(1, 0, 3'd2, 32'h44, 0, 32'h5A5A_0002, 1,
                     st2, rs2, we, ad, wd, be, rd, cn, us, to2);
        exp_rd = 32'h5A5A_0002; exp_cnt += 4;
        total_cnt++;
        if (to1 || to2 || st1 != 2 || st2 != 2)
            $display("FAIL b2b_stalls got %0d,%0d want 2,2", st1, st2);
        else pass_cnt++;
        total_cnt++;
        if (rs1 + rs2 != 2 || ad !== 32'h44) $display("FAIL b2b_reqs got %0d addr=%h want 2 00000044", rs1 + rs2, ad);
        else pass_cnt++;
        total_cnt++;
        if (cn !== 32'(exp_cnt) || cn !== 32'd4) $display("FAIL b2b_cnt got %0d want 4", cn); else pass_cnt++;
        total_cnt++;
        if (rd !== exp_rd) $display("FAIL b2b_rdata got %h want %h", rd, exp_rd); else pass_cnt++;
    endtask

    task automatic test_random;
        int st, rs, n, kind; logic we; logic [31:0] ad, wd, rd, cn; logic [3:0] be; bit us, to;
        logic rdf, wrf; logic [2:0] f3; logic [31:0] a, d, md;
        for (int t = 0; t < 30; t++) begin
            kind = $urandom_range(0, 3);
            rdf = (kind == 1 || kind == 3);
            wrf = (kind == 2 || kind == 3);
            if (wrf) f3 = 3'($urandom_range(0, 2));
            else begin
                f3 = 3'($urandom_range(0, 5));
                if (f3 == 3'd3) f3 = 3'd4;
            end
            a = $urandom; d = $urandom; md = $urandom;
            n = $urandom_range(1, 6);
            drive_access(rdf, wrf, f3, a, d, md, n, st, rs, we, ad, wd, be, rd, cn, us, to);
            if (kind != 0) exp_cnt += n + 1;
            if (kind == 1) exp_rd = ref_load(f3, a, md);
            total_cnt++;
            if (to || st != ((kind != 0) ? n + 1 : 0) || rs != ((kind != 0) ? 1 : 0))
                $display("FAIL rnd%0d_timing got stalls=%0d reqs=%0d want %0d %0d",
                         t, st, rs, (kind != 0) ? n + 1 : 0, (kind != 0) ? 1 : 0);
            else pass_cnt++;
            if (kind != 0) begin
                total_cnt++;
                if (we !== wrf || ad !== {a[31:2], 2'b00} || be !== ref_be(wrf, f3, a) ||
                    (wrf && wd !== ref_wdata(wrf, f3, d)) || us)
                    $display("FAIL rnd%0d_req got we=%b addr=%h be=%h wd=%h want %b %h %h %h",
                             t, we, ad, be, wd, wrf, {a[31:2], 2'b00}, ref_be(wrf, f3, a), ref_wdata(wrf, f3, d));
                else pass_cnt++;
            end
            total_cnt++;
            if (rd !== exp_rd || cn !== 32'(exp_cnt))
                $display("FAIL rnd%0d_result got rd=%h cnt=%0d want %h %0d", t, rd, cn, exp_rd, exp_cnt);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_lw();
        test_sw();
        test_subword();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
